// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state encodings
// for the parametrised register file.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each lane takes the new data when its strobe is set,
// otherwise keeps the old register contents.
module axil_strb_merge
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
      assign merged[8*gi +: 8] = strb[gi] ? new_data[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite slave register file with independent read/write FSMs.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range addresses with SLVERR.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int TOP    = LSB + IDX_W;

  wr_state_t               wr_state_reg;
  rd_state_t               rd_state_reg;
  logic                    aw_held_reg;
  logic                    w_held_reg;
  logic [IDX_W-1:0]        wr_idx_reg;
  logic                    wr_err_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_W-1:0]       wstrb_reg;
  logic [DATA_WIDTH-1:0]   regs_reg [NUM_REGS];
  logic                    awready_reg;
  logic                    wready_reg;
  logic                    bvalid_reg;
  logic [1:0]              bresp_reg;
  logic                    arready_reg;
  logic                    rvalid_reg;
  logic [1:0]              rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    aw_err;
  logic                    ar_err;
  logic                    aw_held_next;
  logic                    w_held_next;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    unused_addr_bits;

  assign aw_hs        = S_AWVALID && awready_reg;
  assign w_hs         = S_WVALID && wready_reg;
  assign ar_hs        = S_ARVALID && arready_reg;
  assign aw_held_next = aw_held_reg || aw_hs;
  assign w_held_next  = w_held_reg || w_hs;

`ifdef AXIL_REGFILE_SLVERR_EN
  assign aw_err = |S_AWADDR[ADDRESS-1:TOP];
  assign ar_err = |S_ARADDR[ADDRESS-1:TOP];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Byte-offset bits never select anything; upper bits only matter for SLVERR.
  assign unused_addr_bits = ^{S_AWADDR[ADDRESS-1:TOP], S_AWADDR[LSB-1:0],
                              S_ARADDR[ADDRESS-1:TOP], S_ARADDR[LSB-1:0]};

  axil_strb_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_strb_merge (
    .old_word(regs_reg[wr_idx_reg]),
    .new_data(wdata_reg),
    .strb    (wstrb_reg),
    .merged  (merged_word)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_reg <= WR_IDLE;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      wr_idx_reg   <= '0;
      wr_err_reg   <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      case (wr_state_reg)
        WR_IDLE: begin
          if (aw_hs) begin
            wr_idx_reg <= S_AWADDR[TOP-1:LSB];
            wr_err_reg <= aw_err;
          end
          if (w_hs) begin
            wdata_reg <= S_WDATA;
            wstrb_reg <= S_WSTRB;
          end
          aw_held_reg <= aw_held_next;
          w_held_reg  <= w_held_next;
          if (aw_held_next && w_held_next) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            wr_state_reg <= WR_EXEC;
          end else begin
            awready_reg <= !aw_held_next;
            wready_reg  <= !w_held_next;
          end
        end
        WR_EXEC: begin
          if (!wr_err_reg) begin
            regs_reg[wr_idx_reg] <= merged_word;
          end
          aw_held_reg  <= 1'b0;
          w_held_reg   <= 1'b0;
          bvalid_reg   <= 1'b1;
          bresp_reg    <= wr_err_reg ? RESP_SLVERR : RESP_OKAY;
          wr_state_reg <= WR_RESP;
        end
        WR_RESP: begin
          if (S_BREADY) begin
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            wr_state_reg <= WR_IDLE;
          end
        end
        default: wr_state_reg <= WR_IDLE;
      endcase
    end
  end

  // The read samples the array on the same edge as a commit, so it sees the old word.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_reg <= RD_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_reg    <= ar_err ? '0 : regs_reg[S_ARADDR[TOP-1:LSB]];
            rresp_reg    <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rvalid_reg   <= 1'b1;
            arready_reg  <= 1'b0;
            rd_state_reg <= RD_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_RREADY) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign S_AWREADY = awready_reg;
  assign S_WREADY  = wready_reg;
  assign S_BVALID  = bvalid_reg;
  assign S_BRESP   = bresp_reg;
  assign S_ARREADY = arready_reg;
  assign S_RVALID  = rvalid_reg;
  assign S_RRESP   = rresp_reg;
  assign S_RDATA   = rdata_reg;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed self-checking bench for axi4_lite_regfile (32-bit data, 32 registers).
// Out-of-range expectations follow AXIL_REGFILE_SLVERR_EN.
module tb_axi4_lite_regfile;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  int total = 0;
  int bad   = 0;

  axi4_lite_regfile #(
    .ADDRESS   (32),
    .DATA_WIDTH(32),
    .NUM_REGS  (32)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .S_AWADDR (S_AWADDR),
    .S_AWVALID(S_AWVALID),
    .S_AWREADY(S_AWREADY),
    .S_WDATA  (S_WDATA),
    .S_WSTRB  (S_WSTRB),
    .S_WVALID (S_WVALID),
    .S_WREADY (S_WREADY),
    .S_BRESP  (S_BRESP),
    .S_BVALID (S_BVALID),
    .S_BREADY (S_BREADY),
    .S_ARADDR (S_ARADDR),
    .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY),
    .S_RDATA  (S_RDATA),
    .S_RRESP  (S_RRESP),
    .S_RVALID (S_RVALID),
    .S_RREADY (S_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Handshakes AW/W (W leads by 'lead' cycles if positive, AW if negative), then
  // counts edges from the second handshake until BVALID is sampled high.
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead,
                          output logic [1:0] resp, output int lat);
    int c;
    int aw_start;
    int w_start;
    bit aw_done;
    bit w_done;
    bit aw_hs;
    bit w_hs;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0;
    w_done  = 0;
    c = 0;
    lat = 0;
    resp = 2'b11;
    @(posedge ACLK);
    #1;
    S_AWADDR = addr;
    S_WDATA  = data;
    S_WSTRB  = strb;
    while (!(aw_done && w_done)) begin
      S_AWVALID = !aw_done && (c >= aw_start);
      S_WVALID  = !w_done && (c >= w_start);
      @(negedge ACLK);
      aw_hs = S_AWVALID && S_AWREADY;
      w_hs  = S_WVALID && S_WREADY;
      @(posedge ACLK);
      #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      c++;
      if (c > 40) begin
        total++;
        bad++;
        $display("FAIL wr_handshake_timeout addr=%h aw_done=%0d w_done=%0d required both 1", addr, aw_done, w_done);
        break;
      end
    end
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    if (aw_done && w_done) begin
      forever begin
        @(negedge ACLK);
        lat++;
        if (S_BVALID) break;
        if (lat > 40) begin
          total++;
          bad++;
          $display("FAIL bvalid_timeout addr=%h got BVALID=0 required 1", addr);
          break;
        end
      end
      resp = S_BRESP;
    end
    $display("wr addr=%h data=%h strb=%b lead=%0d bresp=%b lat=%0d", addr, data, strb, lead, resp, lat);
  endtask

  task automatic wr_finish();
    S_BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_BREADY = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int c;
    bit hs;
    c = 0;
    lat = 0;
    hs = 0;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    @(posedge ACLK);
    #1;
    S_ARADDR  = addr;
    S_ARVALID = 1'b1;
    while (!hs) begin
      @(negedge ACLK);
      hs = S_ARVALID && S_ARREADY;
      @(posedge ACLK);
      #1;
      c++;
      if (!hs && c > 40) begin
        total++;
        bad++;
        $display("FAIL rd_handshake_timeout addr=%h got ARREADY=0 required 1", addr);
        break;
      end
    end
    S_ARVALID = 1'b0;
    if (hs) begin
      forever begin
        @(negedge ACLK);
        lat++;
        if (S_RVALID) break;
        if (lat > 40) begin
          total++;
          bad++;
          $display("FAIL rvalid_timeout addr=%h got RVALID=0 required 1", addr);
          break;
        end
      end
      data = S_RDATA;
      resp = S_RRESP;
    end
    $display("rd addr=%h rdata=%h rresp=%b lat=%0d", addr, data, resp, lat);
  endtask

  task automatic rd_finish();
    S_RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID} !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshake got awr/wr/arr/bv/rv=%b required 00000",
               {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID});
    end
    total++;
    if ({S_BRESP, S_RRESP} !== 4'b0 || S_RDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h required 0/0/0", S_BRESP, S_RRESP, S_RDATA);
    end
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin
      bad++;
      $display("FAIL reset_ready_rise got awr/wr/arr=%b required 111", {S_AWREADY, S_WREADY, S_ARREADY});
    end
    $display("reset released, readies=%b", {S_AWREADY, S_WREADY, S_ARREADY});
  endtask

  task automatic test_idle_read();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    rd_issue(32'h04, d, r, lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL idle_read_latency got %0d required 1", lat);
    end
    total++;
    if (d !== 32'h0 || r !== 2'b00) begin
      bad++;
      $display("FAIL idle_read_data got %h/%b required 00000000/00", d, r);
    end
    rd_finish();
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    wr_issue(32'h08, 32'hDEADBEEF, 4'hF, 3, r, lat);
    total++;
    if (lat !== 2 || r !== 2'b00) begin
      bad++;
      $display("FAIL w_before_aw_resp got lat=%0d bresp=%b required lat=2 bresp=00", lat, r);
    end
    wr_finish();
    rd_issue(32'h08, d, r, lat);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      bad++;
      $display("FAIL w_before_aw_read got %h/%b required deadbeef/00", d, r);
    end
    rd_finish();
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    wr_issue(32'h08, 32'h11223344, 4'b0101, 0, r, lat);
    total++;
    if (lat !== 2 || r !== 2'b00) begin
      bad++;
      $display("FAIL strobe_resp got lat=%0d bresp=%b required lat=2 bresp=00", lat, r);
    end
    wr_finish();
    rd_issue(32'h08, d, r, lat);
    total++;
    if (d !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL strobe_read got %h required de22be44", d);
    end
    rd_finish();
    rd_issue(32'h0B, d, r, lat);
    total++;
    if (d !== 32'hDE22BE44) begin
      bad++;
      $display("FAIL byte_offset_ignored got %h required de22be44", d);
    end
    rd_finish();
  endtask

  task automatic test_aw_first();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    wr_issue(32'h14, 32'hCAFEF00D, 4'hF, -2, r, lat);
    total++;
    if (lat !== 2 || r !== 2'b00) begin
      bad++;
      $display("FAIL aw_first_resp got lat=%0d bresp=%b required lat=2 bresp=00", lat, r);
    end
    wr_finish();
    rd_issue(32'h14, d, r, lat);
    total++;
    if (d !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL aw_first_read got %h required cafef00d", d);
    end
    rd_finish();
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    wr_issue(32'h10, 32'hA5A5A5A5, 4'hF, 0, r, lat);
    rd_issue(32'h08, d, r, lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00 || S_RVALID !== 1'b1 || S_RDATA !== 32'hDE22BE44) begin
        bad++;
        $display("FAIL backpressure_hold[%0d] got bv=%b bresp=%b rv=%b rdata=%h required 1/00/1/de22be44",
                 i, S_BVALID, S_BRESP, S_RVALID, S_RDATA);
      end
      total++;
      if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
        bad++;
        $display("FAIL backpressure_ready[%0d] got awr/wr/arr=%b required 000", i, {S_AWREADY, S_WREADY, S_ARREADY});
      end
      @(negedge ACLK);
    end
    wr_finish();
    total++;
    if ({S_AWREADY, S_WREADY, S_BVALID, S_RVALID} !== 4'b1101) begin
      bad++;
      $display("FAIL backpressure_b_release got awr/wr/bv/rv=%b required 1101", {S_AWREADY, S_WREADY, S_BVALID, S_RVALID});
    end
    rd_finish();
    total++;
    if ({S_ARREADY, S_RVALID} !== 2'b10) begin
      bad++;
      $display("FAIL backpressure_r_release got arr/rv=%b required 10", {S_ARREADY, S_RVALID});
    end
    rd_issue(32'h10, d, r, lat);
    total++;
    if (d !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL backpressure_write_data got %h required a5a5a5a5", d);
    end
    rd_finish();
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    wr_issue(32'h0C, 32'h1, 4'hF, 0, r, lat);
    wr_finish();
    // AW+W handshake at edge N, AR at edge N+1 which is also the commit edge.
    @(posedge ACLK);
    #1;
    S_AWADDR  = 32'h0C;
    S_WDATA   = 32'h5;
    S_WSTRB   = 4'hF;
    S_AWVALID = 1'b1;
    S_WVALID  = 1'b1;
    @(posedge ACLK);
    #1;
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    S_ARADDR  = 32'h0C;
    S_ARVALID = 1'b1;
    @(posedge ACLK);
    #1;
    S_ARVALID = 1'b0;
    $display("collision rd addr=0000000c rvalid=%b rdata=%h bvalid=%b", S_RVALID, S_RDATA, S_BVALID);
    total++;
    if (S_RVALID !== 1'b1 || S_RDATA !== 32'h1) begin
      bad++;
      $display("FAIL collision_old_value got rv=%b rdata=%h required 1/00000001", S_RVALID, S_RDATA);
    end
    total++;
    if (S_BVALID !== 1'b1) begin
      bad++;
      $display("FAIL collision_bvalid got %b required 1", S_BVALID);
    end
    S_BREADY = 1'b1;
    S_RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_BREADY = 1'b0;
    S_RREADY = 1'b0;
    rd_issue(32'h0C, d, r, lat);
    total++;
    if (d !== 32'h5) begin
      bad++;
      $display("FAIL collision_new_value got %h required 00000005", d);
    end
    rd_finish();
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_reg0;
    logic [31:0] exp_oor_data;
`ifdef AXIL_REGFILE_SLVERR_EN
    exp_resp     = 2'b10;
    exp_reg0     = 32'h0;
    exp_oor_data = 32'h0;
`else
    exp_resp     = 2'b00;
    exp_reg0     = 32'h77;
    exp_oor_data = 32'h77;
`endif
    wr_issue(32'h80, 32'h77, 4'hF, 0, r, lat);
    total++;
    if (r !== exp_resp || lat !== 2) begin
      bad++;
      $display("FAIL oor_write_resp got bresp=%b lat=%0d required bresp=%b lat=2", r, lat, exp_resp);
    end
    wr_finish();
    rd_issue(32'h00, d, r, lat);
    total++;
    if (d !== exp_reg0 || r !== 2'b00) begin
      bad++;
      $display("FAIL oor_reg0 got %h/%b required %h/00", d, r, exp_reg0);
    end
    rd_finish();
    rd_issue(32'h80, d, r, lat);
    total++;
    if (d !== exp_oor_data || r !== exp_resp || lat !== 1) begin
      bad++;
      $display("FAIL oor_read got %h/%b lat=%0d required %h/%b lat=1", d, r, lat, exp_oor_data, exp_resp);
    end
    rd_finish();
  endtask

  initial begin
    ARESET    = 1'b1;
    S_AWADDR  = '0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b0;
    S_ARADDR  = '0;
    S_ARVALID = 1'b0;
    S_RREADY  = 1'b0;
    test_reset();
    test_idle_read();
    test_w_before_aw();
    test_partial_strobe();
    test_aw_first();
    test_backpressure();
    test_collision();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
